// File: rtl/overcooked_pkg.sv
// Shared definitions for the kitchen game datapath.
//   facing_t  : player facing encoding (0 up, 1 down, 2 left, 3 right)
//   DIR_*     : bit positions inside the {up,down,left,right} button vector
//   TILE_PX, GRID_W, GRID_H, SCREEN_W, SCREEN_H : playfield geometry
//   tile_t    : kitchen tile map cell contents
package overcooked_pkg;

    localparam int TILE_PX  = 32;
    localparam int GRID_W   = 11;
    localparam int GRID_H   = 9;
    localparam int SCREEN_W = GRID_W * TILE_PX;
    localparam int SCREEN_H = GRID_H * TILE_PX;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        FACE_UP    = 2'd0,
        FACE_DOWN  = 2'd1,
        FACE_LEFT  = 2'd2,
        FACE_RIGHT = 2'd3
    } facing_t;

    typedef enum logic [1:0] {
        TILE_FLOOR   = 2'd0,
        TILE_COUNTER = 2'd1,
        TILE_WALL    = 2'd2,
        TILE_STATION = 2'd3
    } tile_t;

    // Only bare floor can be walked on.
    function automatic logic tile_is_blocked(input tile_t t);
        return (t != TILE_FLOOR);
    endfunction

endpackage

// File: rtl/pixel_to_grid.sv
// Pixel coordinate to tile cell conversion.
//   pix_x, pix_y   in  9  pixel coordinate
//   cell_x, cell_y out 4  tile column / row (coord >> log2(TILE_PX))
module pixel_to_grid #(
    parameter int TILE_PX = 32
) (
    input  logic [8:0] pix_x,
    input  logic [8:0] pix_y,
    output logic [3:0] cell_x,
    output logic [3:0] cell_y
);

    localparam int SHIFT = $clog2(TILE_PX);

    assign cell_x = 4'(pix_x >> SHIFT);
    assign cell_y = 4'(pix_y >> SHIFT);

endmodule

// File: rtl/player_mover.sv
// Per-frame player position controller.
// On each frame tick the button levels are latched, then the X axis and the
// Y axis are stepped in turn. Each step queries the tile map at the two
// leading-edge corners of the candidate sprite box and is cancelled if
// either corner is impassable.
// Ports:
//   clk_in, rst_in         clock, synchronous active-high reset
//   frame_tick_in          one-cycle pulse per video frame
//   dir_in[3:0]            {up,down,left,right} button levels
//   map_req_out            tile-map request, held until map_valid_in
//   map_x_out, map_y_out   tile column / row being queried
//   map_valid_in           tile-map response strobe
//   map_blocked_in         1 = queried tile impassable
//   x_coord_out, y_coord_out player top-left pixel position
//   facing_out             0 up, 1 down, 2 left, 3 right
//   busy_out               update in progress (frame ticks dropped)
// Build option:
//   PLAYER_MOVER_SPRINT_EN adds sprint_in; when set the step is 2*SPEED.
module player_mover
    import overcooked_pkg::*;
#(
    parameter int TILE_PX   = overcooked_pkg::TILE_PX,
    parameter int GRID_W    = overcooked_pkg::GRID_W,
    parameter int GRID_H    = overcooked_pkg::GRID_H,
    parameter int PLAYER_PX = 24,
    parameter int SPEED     = 2,
    parameter int START_X   = 64,
    parameter int START_Y   = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_tick_in,
    input  logic [3:0] dir_in,
`ifdef PLAYER_MOVER_SPRINT_EN
    input  logic       sprint_in,
`endif
    output logic       map_req_out,
    output logic [3:0] map_x_out,
    output logic [3:0] map_y_out,
    input  logic       map_valid_in,
    input  logic       map_blocked_in,
    output logic [8:0] x_coord_out,
    output logic [8:0] y_coord_out,
    output logic [1:0] facing_out,
    output logic       busy_out
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_X_A  = 3'd1;
    localparam logic [2:0] ST_X_B  = 3'd2;
    localparam logic [2:0] ST_Y_A  = 3'd3;
    localparam logic [2:0] ST_Y_B  = 3'd4;

    localparam logic [8:0] X_MAX    = 9'(GRID_W * TILE_PX - PLAYER_PX);
    localparam logic [8:0] Y_MAX    = 9'(GRID_H * TILE_PX - PLAYER_PX);
    localparam logic [8:0] EDGE_OFS = 9'(PLAYER_PX - 1);
    localparam logic [4:0] STEP_N   = 5'(SPEED);
`ifdef PLAYER_MOVER_SPRINT_EN
    localparam logic [4:0] STEP_S   = 5'(2 * SPEED);
`endif

    logic [2:0] state;
    logic       waiting;     // request outstanding for the current corner
    logic [3:0] dir_q;
    logic [4:0] step_q;
    logic [8:0] x_pos;
    logic [8:0] y_pos;
    facing_t    facing_q;

    logic       is_x;
    logic       is_a;
    logic       move_pos;    // moving towards larger coordinates
    logic [8:0] cur_pos;
    logic [8:0] cand;
    logic [8:0] lead;
    logic [8:0] pix_x;
    logic [8:0] pix_y;
    logic [3:0] cell_x;
    logic [3:0] cell_y;
    logic       x_act;
    logic       y_act;
    logic       tick_x_act;
    logic       tick_y_act;
    logic [2:0] pass_next;

    // Step in 10-bit signed space so a move left of zero goes negative
    // before it is pulled back into the playfield.
    function automatic logic [8:0] clamp_step(
        input logic [8:0] pos,
        input logic [4:0] step,
        input logic       neg,
        input logic [8:0] max
    );
        logic signed [9:0] c;
        logic signed [9:0] d;
        d = $signed({5'b0, step});
        c = neg ? ($signed({1'b0, pos}) - d) : ($signed({1'b0, pos}) + d);
        if (c < 10'sd0)
            return 9'd0;
        else if (c > $signed({1'b0, max}))
            return max;
        else
            return c[8:0];
    endfunction

    // An axis is active only when exactly one of its two buttons is held.
    assign x_act      = dir_q[DIR_RIGHT] ^ dir_q[DIR_LEFT];
    assign y_act      = dir_q[DIR_DOWN] ^ dir_q[DIR_UP];
    assign tick_x_act = dir_in[DIR_RIGHT] ^ dir_in[DIR_LEFT];
    assign tick_y_act = dir_in[DIR_DOWN] ^ dir_in[DIR_UP];

    always_comb begin
        is_x     = (state == ST_X_A) || (state == ST_X_B);
        is_a     = (state == ST_X_A) || (state == ST_Y_A);
        move_pos = is_x ? dir_q[DIR_RIGHT] : dir_q[DIR_DOWN];
        cur_pos  = is_x ? x_pos : y_pos;
        cand     = clamp_step(cur_pos, step_q, ~move_pos, is_x ? X_MAX : Y_MAX);
        lead     = move_pos ? (cand + EDGE_OFS) : cand;
        if (is_x) begin
            pix_x = lead;
            pix_y = is_a ? y_pos : (y_pos + EDGE_OFS);
        end else begin
            pix_x = is_a ? x_pos : (x_pos + EDGE_OFS);
            pix_y = lead;
        end
        // The Y pass follows X only when Y has something to do.
        pass_next = (is_x && y_act) ? ST_Y_A : ST_IDLE;
    end

    pixel_to_grid #(
        .TILE_PX (TILE_PX)
    ) u_p2g (
        .pix_x  (pix_x),
        .pix_y  (pix_y),
        .cell_x (cell_x),
        .cell_y (cell_y)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            waiting     <= 1'b0;
            dir_q       <= 4'd0;
            step_q      <= STEP_N;
            x_pos       <= 9'(START_X);
            y_pos       <= 9'(START_Y);
            facing_q    <= FACE_DOWN;
            map_req_out <= 1'b0;
            map_x_out   <= 4'd0;
            map_y_out   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick_in) begin
                        dir_q <= dir_in;
`ifdef PLAYER_MOVER_SPRINT_EN
                        step_q <= sprint_in ? STEP_S : STEP_N;
`else
                        step_q <= STEP_N;
`endif
                        if (tick_x_act)
                            state <= ST_X_A;
                        else if (tick_y_act)
                            state <= ST_Y_A;
                    end
                end
                ST_X_A, ST_X_B, ST_Y_A, ST_Y_B: begin
                    if (!waiting) begin
                        // Facing follows the axis being processed even if
                        // the step later turns out to be blocked.
                        if (state == ST_X_A)
                            facing_q <= dir_q[DIR_RIGHT] ? FACE_RIGHT : FACE_LEFT;
                        else if (state == ST_Y_A)
                            facing_q <= dir_q[DIR_DOWN] ? FACE_DOWN : FACE_UP;

                        // Already pinned against the playfield edge: nothing
                        // to check, the pass ends without a map query.
                        if (cand == cur_pos) begin
                            state <= pass_next;
                        end else begin
                            map_req_out <= 1'b1;
                            waiting     <= 1'b1;
                            map_x_out   <= cell_x;
                            map_y_out   <= cell_y;
                        end
                    end else if (map_valid_in) begin
                        map_req_out <= 1'b0;
                        waiting     <= 1'b0;
                        if (map_blocked_in) begin
                            state <= pass_next;
                        end else if (is_a) begin
                            state <= (state == ST_X_A) ? ST_X_B : ST_Y_B;
                        end else begin
                            if (is_x)
                                x_pos <= cand;
                            else
                                y_pos <= cand;
                            state <= pass_next;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    waiting     <= 1'b0;
                    map_req_out <= 1'b0;
                end
            endcase
        end
    end

    assign x_coord_out = x_pos;
    assign y_coord_out = y_pos;
    assign facing_out  = facing_q;
    assign busy_out    = (state != ST_IDLE);

endmodule

// File: tb/tb_player_mover.sv
module tb_player_mover;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] dir;
`ifdef PLAYER_MOVER_SPRINT_EN
    logic       sprint;
`endif
    logic       map_req;
    logic [3:0] map_x;
    logic [3:0] map_y;
    logic       map_valid;
    logic       map_blocked;
    logic [8:0] x_coord;
    logic [8:0] y_coord;
    logic [1:0] facing;
    logic       busy;

    int total;
    int bad;

    // Tile map model: blk[row][col], one-cycle response latency.
    bit         blk [0:15][0:15];
    bit         hold;
    logic [7:0] qlog [$];

    typedef struct {
        logic [3:0] dir;
        logic [8:0] x;
        logic [8:0] y;
        logic [1:0] f;
    } vec_t;

    vec_t vecs [8];
    vec_t exp_q [$];

    player_mover dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .frame_tick_in  (tick),
        .dir_in         (dir),
`ifdef PLAYER_MOVER_SPRINT_EN
        .sprint_in      (sprint),
`endif
        .map_req_out    (map_req),
        .map_x_out      (map_x),
        .map_y_out      (map_y),
        .map_valid_in   (map_valid),
        .map_blocked_in (map_blocked),
        .x_coord_out    (x_coord),
        .y_coord_out    (y_coord),
        .facing_out     (facing),
        .busy_out       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            map_valid <= 1'b0;
        end else if (map_req && !map_valid && !hold) begin
            map_valid   <= 1'b1;
            map_blocked <= blk[map_y][map_x];
            qlog.push_back({map_x, map_y});
        end else begin
            map_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Returns #1 after the edge that samples the tick.
    task automatic do_tick(input logic [3:0] d);
        @(posedge clk); #1;
        tick = 1'b1;
        dir  = d;
        @(posedge clk); #1;
        tick = 1'b0;
        dir  = 4'd0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, cycles);
        end
    endtask

    task automatic tick_and_check(input string name, input vec_t v);
        vec_t e;
        int   cyc;
        exp_q.push_back(v);
        do_tick(v.dir);
        wait_idle(cyc);
        e = exp_q.pop_front();
        check({name, "_x"}, 32'(x_coord), 32'(e.x));
        check({name, "_y"}, 32'(y_coord), 32'(e.y));
        check({name, "_f"}, 32'(facing), 32'(e.f));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        vec_t v;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        tick  = 1'b0;
        dir   = 4'd0;
        hold  = 1'b0;
`ifdef PLAYER_MOVER_SPRINT_EN
        sprint = 1'b0;
`endif
        foreach (blk[r, c]) blk[r][c] = 1'b0;

        // dir = {up,down,left,right}; expectations chained from reset 64,64 facing down
        vecs[0] = '{4'b0100, 9'd64, 9'd66, 2'd1};  // down
        vecs[1] = '{4'b0101, 9'd66, 9'd68, 2'd1};  // down+right, Y sets facing
        vecs[2] = '{4'b1000, 9'd66, 9'd66, 2'd0};  // up
        vecs[3] = '{4'b0010, 9'd64, 9'd66, 2'd2};  // left
        vecs[4] = '{4'b1111, 9'd64, 9'd66, 2'd2};  // both axes cancelled
        vecs[5] = '{4'b1011, 9'd64, 9'd64, 2'd0};  // x cancelled, up
        vecs[6] = '{4'b0000, 9'd64, 9'd64, 2'd0};  // idle tick
        vecs[7] = '{4'b1010, 9'd62, 9'd62, 2'd0};  // up+left diagonal

        // reset state
        do_reset();
        check("rst_x", 32'(x_coord), 32'd64);
        check("rst_y", 32'(y_coord), 32'd64);
        check("rst_facing", 32'(facing), 32'd1);
        check("rst_req", 32'(map_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // single right step, latency and queried cells
        qlog.delete();
        exp_q.push_back('{4'b0001, 9'd66, 9'd64, 2'd3});
        do_tick(4'b0001);
        wait_idle(cyc);
        v = exp_q.pop_front();
        check("right_latency_ok", 32'(cyc <= 9), 32'd1);
        check("right_x", 32'(x_coord), 32'(v.x));
        check("right_y", 32'(y_coord), 32'(v.y));
        check("right_facing", 32'(facing), 32'(v.f));
        check("right_nq", 32'(qlog.size()), 32'd2);
        if (qlog.size() == 2) begin
            check("right_qA", 32'(qlog[0]), 32'h22);
            check("right_qB", 32'(qlog[1]), 32'h22);
        end

        // three more rights to 72, then block cell (3,2)
        for (int i = 0; i < 3; i++)
            tick_and_check("walk", '{4'b0001, 9'(68 + 2 * i), 9'd64, 2'd3});
        blk[2][3] = 1'b1;
        qlog.delete();
        tick_and_check("blocked", '{4'b0001, 9'd72, 9'd64, 2'd3});
        check("blocked_nq", 32'(qlog.size()), 32'd1);
        if (qlog.size() == 1)
            check("blocked_q", 32'(qlog[0]), 32'h32);
        blk[2][3] = 1'b0;

        // table of mixed directions from a fresh start
        do_reset();
        for (int i = 0; i < 8; i++)
            tick_and_check($sformatf("vec%0d", i), vecs[i]);

        // left held into the wall at x=0
        do_reset();
        for (int i = 0; i < 32; i++) begin
            do_tick(4'b0010);
            wait_idle(cyc);
        end
        check("left_reach_x", 32'(x_coord), 32'd0);
        qlog.delete();
        for (int i = 0; i < 8; i++)
            tick_and_check("left_hold", '{4'b0010, 9'd0, 9'd64, 2'd2});
        check("left_edge_nq", 32'(qlog.size()), 32'd0);

        // y cancelled, x steps, second tick while busy is dropped
        do_reset();
        exp_q.push_back('{4'b1101, 9'd66, 9'd64, 2'd3});
        do_tick(4'b1101);
        check("busy_high", 32'(busy), 32'd1);
        tick = 1'b1;
        dir  = 4'b0001;
        @(posedge clk); #1;
        tick = 1'b0;
        dir  = 4'd0;
        wait_idle(cyc);
        repeat (12) @(posedge clk);
        #1;
        v = exp_q.pop_front();
        check("drop_x", 32'(x_coord), 32'(v.x));
        check("drop_y", 32'(y_coord), 32'(v.y));
        check("drop_facing", 32'(facing), 32'(v.f));
        check("drop_busy", 32'(busy), 32'd0);

        // reset while a map request is outstanding
        do_reset();
        hold = 1'b1;
        do_tick(4'b0001);
        cyc = 0;
        while (!map_req && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("hold_req_seen", 32'(map_req), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_req", 32'(map_req), 32'd0);
        check("abort_x", 32'(x_coord), 32'd64);
        check("abort_y", 32'(y_coord), 32'd64);
        check("abort_busy", 32'(busy), 32'd0);
        rst  = 1'b0;
        hold = 1'b0;
        qlog.delete();
        repeat (6) @(posedge clk);
        #1;
        check("after_abort_req", 32'(map_req), 32'd0);
        check("after_abort_x", 32'(x_coord), 32'd64);
        check("after_abort_nq", 32'(qlog.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
